// File: rtl/cache_writeback_buffer_if.sv
// Cache-side and memory-side line transfer signals of the writeback buffer.
// Latency: none, wires only.
// Backpressure: the cache and memory sides each hold a request until its resp pulse.
interface cache_writeback_buffer_if;
    logic [15:0]  cache_address;
    logic         cache_read;
    logic         cache_write;
    logic [127:0] cache_wdata;
    logic         cache_resp;
    logic [127:0] cache_rdata;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic [2:0]   buf_count;

    // Environment side: drives cache requests and memory responses.
    modport master (
        output cache_address, cache_read, cache_write, cache_wdata,
        output pmem_resp, pmem_rdata,
        input  cache_resp, cache_rdata,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  buf_count
    );

    // Buffer side.
    modport slave (
        input  cache_address, cache_read, cache_write, cache_wdata,
        input  pmem_resp, pmem_rdata,
        output cache_resp, cache_rdata,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        output buf_count
    );
endinterface

// File: rtl/cache_writeback_buffer.sv
// Writeback buffer between L1 and memory: absorbs evictions, forwards hits, drains when idle or full.
// Latency: buffered write / forward hit respond 2 cycles after acceptance; read miss 2 cycles after pmem_resp.
// Backpressure: cache requests are held until cache_resp; a write into a full buffer waits for one drain.
module cache_writeback_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    cache_writeback_buffer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RESP, MEM_RD, DRAIN} state_t;

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    state_t             state_q, state_nxt;
    logic [2:0]         count_q, count_nxt;
    logic [DEPTH-1:0]   vld_q, vld_nxt;
    logic [11:0]        tag_q  [DEPTH];
    logic [11:0]        tag_nxt[DEPTH];
    logic [127:0]       data_q  [DEPTH];
    logic [127:0]       data_nxt[DEPTH];

    logic               cache_resp_q, cache_resp_nxt;
    logic [127:0]       cache_rdata_q, cache_rdata_nxt;
    logic [15:0]        pmem_address_q, pmem_address_nxt;
    logic               pmem_read_q, pmem_read_nxt;
    logic               pmem_write_q, pmem_write_nxt;
    logic [127:0]       pmem_wdata_q, pmem_wdata_nxt;

    logic [11:0]        req_tag;
    logic               hit;
    logic [DEPTH-1:0]   hit_sel;
    logic [127:0]       hit_data;
    logic               start_drain;
    logic [3:0]         unused_addr_bits;

    assign req_tag          = bus.cache_address[15:4];
    assign unused_addr_bits = bus.cache_address[3:0];

    // Tag lookup: coalescing keeps at most one valid entry per tag, so the hit is unique.
    always_comb begin
        hit      = 1'b0;
        hit_sel  = '0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (tag_q[i] == req_tag)) begin
                hit        = 1'b1;
                hit_sel[i] = 1'b1;
                hit_data   = data_q[i];
            end
        end
    end

    // Next-state and next-output logic; entry 0 is the FIFO head.
    always_comb begin
        state_nxt        = state_q;
        count_nxt        = count_q;
        vld_nxt          = vld_q;
        tag_nxt          = tag_q;
        data_nxt         = data_q;
        cache_resp_nxt   = 1'b0;
        cache_rdata_nxt  = cache_rdata_q;
        pmem_address_nxt = pmem_address_q;
        pmem_read_nxt    = pmem_read_q;
        pmem_write_nxt   = pmem_write_q;
        pmem_wdata_nxt   = pmem_wdata_q;
        start_drain      = 1'b0;

        case (state_q)
            IDLE: begin
                // While cache_resp is high the cache is still retiring its last request.
                if (!cache_resp_q) begin
                    if (bus.cache_write) begin
                        if (hit) begin
                            for (int i = 0; i < DEPTH; i++) begin
                                if (hit_sel[i]) data_nxt[i] = bus.cache_wdata;
                            end
                            state_nxt = RESP;
                        end else if (count_q < DEPTH_C) begin
                            for (int i = 0; i < DEPTH; i++) begin
                                if (3'(i) == count_q) begin
                                    vld_nxt[i]  = 1'b1;
                                    tag_nxt[i]  = req_tag;
                                    data_nxt[i] = bus.cache_wdata;
                                end
                            end
                            count_nxt = count_q + 3'd1;
                            state_nxt = RESP;
                        end else begin
                            start_drain = 1'b1;
                        end
                    end else if (bus.cache_read) begin
                        if (hit) begin
                            cache_rdata_nxt = hit_data;
                            state_nxt       = RESP;
                        end else begin
                            // No entry holds this line, so memory is already up to date for it.
                            pmem_address_nxt = {req_tag, 4'b0000};
                            pmem_read_nxt    = 1'b1;
                            state_nxt        = MEM_RD;
                        end
                    end else if (count_q != 3'd0) begin
                        start_drain = 1'b1;
                    end
                end
            end
            RESP: begin
                cache_resp_nxt = 1'b1;
                state_nxt      = IDLE;
            end
            MEM_RD: begin
                if (bus.pmem_resp) begin
                    cache_rdata_nxt = bus.pmem_rdata;
                    pmem_read_nxt   = 1'b0;
                    state_nxt       = RESP;
                end
            end
            DRAIN: begin
                if (bus.pmem_resp) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        tag_nxt[i]  = tag_q[i+1];
                        data_nxt[i] = data_q[i+1];
                    end
                    vld_nxt        = vld_q >> 1;
                    count_nxt      = count_q - 3'd1;
                    pmem_write_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (start_drain) begin
            pmem_address_nxt = {tag_q[0], 4'b0000};
            pmem_wdata_nxt   = data_q[0];
            pmem_write_nxt   = 1'b1;
            state_nxt        = DRAIN;
        end
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            count_q        <= '0;
            vld_q          <= '0;
            cache_resp_q   <= 1'b0;
            cache_rdata_q  <= '0;
            pmem_address_q <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_wdata_q   <= '0;
        end else begin
            state_q        <= state_nxt;
            count_q        <= count_nxt;
            vld_q          <= vld_nxt;
            cache_resp_q   <= cache_resp_nxt;
            cache_rdata_q  <= cache_rdata_nxt;
            pmem_address_q <= pmem_address_nxt;
            pmem_read_q    <= pmem_read_nxt;
            pmem_write_q   <= pmem_write_nxt;
            pmem_wdata_q   <= pmem_wdata_nxt;
        end
    end

    // Entry payload storage; validity is tracked separately so payload needs no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_nxt;
        data_q <= data_nxt;
    end

    assign bus.cache_resp   = cache_resp_q;
    assign bus.cache_rdata  = cache_rdata_q;
    assign bus.pmem_address = pmem_address_q;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_wdata   = pmem_wdata_q;
    assign bus.buf_count    = count_q;

endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Directed bench for cache_writeback_buffer with DEPTH=2 and a latency-programmable memory model.
// Latency: memory answers mem_lat cycles after a request first appears.
// Backpressure: requests are held until the matching resp pulse, as the real cache and memory do.
module tb_cache_writeback_buffer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_writeback_buffer_if bus();

    cache_writeback_buffer #(.DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Memory model log: one record per memory transaction, in issue order.
    bit           ev_wr  [$];
    logic [15:0]  ev_addr[$];
    logic [127:0] ev_data[$];
    int           mem_lat   = 3;
    logic [127:0] mem_rdata = '0;
    bit           both_seen = 1'b0;
    bit           over_seen = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        ev_wr.delete();
        ev_addr.delete();
        ev_data.delete();
    endtask

    // One cache request, held until cache_resp; returns the cycles taken and the read data.
    task automatic cache_op(input string tag, input bit wr, input logic [15:0] addr,
                            input logic [127:0] wd, output int lat, output logic [127:0] rd);
        bus.cache_address = addr;
        bus.cache_write   = wr;
        bus.cache_read    = !wr;
        bus.cache_wdata   = wd;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.cache_resp && lat < 60);
        chk({tag, "_resp"}, 128'(bus.cache_resp), 128'(1));
        rd = bus.cache_rdata;
        bus.cache_read  = 1'b0;
        bus.cache_write = 1'b0;
    endtask

    task automatic wait_ev(input string tag, input int n);
        int c = 0;
        while (ev_addr.size() < n && c < 60) begin
            @(posedge clk); #1;
            c++;
        end
        chk(tag, 128'(ev_addr.size() >= n), 128'(1));
    endtask

    task automatic wait_empty(input string tag);
        int c = 0;
        while (bus.buf_count != 3'd0 && c < 60) begin
            @(posedge clk); #1;
            c++;
        end
        chk(tag, 128'(bus.buf_count), 128'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Memory model: logs each request, checks it is held stable, then pulses pmem_resp.
    initial begin
        logic [15:0]  r_addr;
        logic [127:0] r_data;
        bit           r_wr, r_stable, r_abort;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (!reset && (bus.pmem_read || bus.pmem_write)) begin
                r_wr     = bus.pmem_write;
                r_addr   = bus.pmem_address;
                r_data   = bus.pmem_wdata;
                r_stable = 1'b1;
                r_abort  = 1'b0;
                ev_wr.push_back(r_wr);
                ev_addr.push_back(r_addr);
                ev_data.push_back(r_wr ? r_data : 128'h0);
                for (int k = 1; k < mem_lat && !r_abort; k++) begin
                    @(posedge clk); #2;
                    if (reset) r_abort = 1'b1;
                    else if (bus.pmem_address !== r_addr || bus.pmem_write !== r_wr ||
                             bus.pmem_read !== !r_wr || (r_wr && bus.pmem_wdata !== r_data))
                        r_stable = 1'b0;
                end
                if (!r_abort) begin
                    bus.pmem_rdata = mem_rdata;
                    bus.pmem_resp  = 1'b1;
                    @(posedge clk); #2;
                    bus.pmem_resp  = 1'b0;
                    chk("pmem_hold", 128'(r_stable), 128'(1));
                end
            end
        end
    end

    // Invariants watched every cycle, reported once at the end.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.pmem_read && bus.pmem_write) both_seen = 1'b1;
            if (bus.buf_count > 3'd2) over_seen = 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int           lat;
        logic [127:0] rd;
        logic [127:0] da, db, dc, dx, d10, d20, d30, d1, d2, de, df;
        da  = {4{32'hAAAA_0001}};
        db  = {4{32'hBBBB_0002}};
        dc  = {4{32'hCCCC_0003}};
        dx  = {4{32'h1000_1000}};
        d10 = {4{32'h0010_0010}};
        d20 = {4{32'h0020_0020}};
        d30 = {4{32'h0030_0030}};
        d1  = {4{32'hD1D1_D1D1}};
        d2  = {4{32'hD2D2_D2D2}};
        de  = {4{32'hEEEE_6660}};
        df  = {4{32'hFFFF_6660}};

        reset             = 1'b1;
        bus.cache_address = '0;
        bus.cache_read    = 1'b0;
        bus.cache_write   = 1'b0;
        bus.cache_wdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count",  128'(bus.buf_count),  128'(0));
        chk("rst_resp",   128'(bus.cache_resp), 128'(0));
        chk("rst_pread",  128'(bus.pmem_read),  128'(0));
        chk("rst_pwrite", 128'(bus.pmem_write), 128'(0));
        chk("rst_paddr",  128'(bus.pmem_address), 128'(0));
        chk("rst_rdata",  bus.cache_rdata, 128'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Eviction accepted quickly, drained once the cache is quiet.
        clear_log();
        cache_op("evict", 1'b1, 16'h1230, da, lat, rd);
        chk("evict_lat",     128'(lat),            128'(2));
        chk("evict_count",   128'(bus.buf_count),  128'(1));
        chk("evict_no_wr",   128'(bus.pmem_write), 128'(0));
        wait_ev("evict_drain", 1);
        chk("evict_is_wr",   128'(ev_wr[0]),   128'(1));
        chk("evict_addr",    128'(ev_addr[0]), 128'(16'h1230));
        chk("evict_data",    ev_data[0],       da);
        wait_empty("evict_empty");

        // Forward hit: read right after the write is served from the buffer.
        clear_log();
        cache_op("fwd_wr", 1'b1, 16'h4440, db, lat, rd);
        cache_op("fwd_rd", 1'b0, 16'h444C, '0, lat, rd);
        chk("fwd_data",    rd, db);
        chk("fwd_no_mem",  128'(ev_addr.size()), 128'(0));
        wait_ev("fwd_drain", 1);
        chk("fwd_drain_wr",   128'(ev_wr[0]),   128'(1));
        chk("fwd_drain_addr", 128'(ev_addr[0]), 128'(16'h4440));
        wait_empty("fwd_empty");

        // Read miss goes to memory ahead of the buffered line.
        clear_log();
        mem_lat   = 5;
        mem_rdata = dc;
        cache_op("miss_wr", 1'b1, 16'h1000, dx, lat, rd);
        cache_op("miss_rd", 1'b0, 16'h2000, '0, lat, rd);
        chk("miss_data",     rd, dc);
        chk("miss_first_rd", 128'(ev_wr[0]),   128'(0));
        chk("miss_rd_addr",  128'(ev_addr[0]), 128'(16'h2000));
        wait_ev("miss_drain", 2);
        chk("miss_drain_wr",   128'(ev_wr[1]),   128'(1));
        chk("miss_drain_addr", 128'(ev_addr[1]), 128'(16'h1000));
        chk("miss_drain_data", ev_data[1], dx);
        wait_empty("miss_empty");
        mem_lat = 3;

        // Full stall: third write waits for the head to drain.
        clear_log();
        cache_op("full_w1", 1'b1, 16'h0010, d10, lat, rd);
        cache_op("full_w2", 1'b1, 16'h0020, d20, lat, rd);
        chk("full_count2", 128'(bus.buf_count), 128'(2));
        cache_op("full_w3", 1'b1, 16'h0030, d30, lat, rd);
        chk("full_ev1",     128'(ev_addr.size()), 128'(1));
        chk("full_head",    128'(ev_addr[0]), 128'(16'h0010));
        chk("full_head_d",  ev_data[0], d10);
        chk("full_count",   128'(bus.buf_count), 128'(2));
        wait_ev("full_drain", 3);
        chk("full_next",    128'(ev_addr[1]), 128'(16'h0020));
        chk("full_next_d",  ev_data[1], d20);
        chk("full_last",    128'(ev_addr[2]), 128'(16'h0030));
        chk("full_last_d",  ev_data[2], d30);
        wait_empty("full_empty");

        // Coalesce: two writes to one line leave a single entry with the newer data.
        clear_log();
        cache_op("coal_w1", 1'b1, 16'h5550, d1, lat, rd);
        cache_op("coal_w2", 1'b1, 16'h5550, d2, lat, rd);
        chk("coal_count", 128'(bus.buf_count), 128'(1));
        wait_ev("coal_drain", 1);
        chk("coal_addr", 128'(ev_addr[0]), 128'(16'h5550));
        chk("coal_data", ev_data[0], d2);
        wait_empty("coal_empty");
        chk("coal_one_drain", 128'(ev_addr.size()), 128'(1));

        // Reset while draining: everything dropped, the line is lost, next read goes to memory.
        clear_log();
        mem_lat = 8;
        cache_op("rst_wr", 1'b1, 16'h6660, de, lat, rd);
        begin
            int c = 0;
            while (!bus.pmem_write && c < 60) begin
                @(posedge clk); #1;
                c++;
            end
            chk("rst_drain_seen", 128'(bus.pmem_write), 128'(1));
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rstd_pwrite", 128'(bus.pmem_write), 128'(0));
        chk("rstd_count",  128'(bus.buf_count),  128'(0));
        chk("rstd_resp",   128'(bus.cache_resp), 128'(0));
        chk("rstd_pread",  128'(bus.pmem_read),  128'(0));
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        clear_log();
        mem_lat   = 3;
        mem_rdata = df;
        cache_op("rstd_rd", 1'b0, 16'h6660, '0, lat, rd);
        chk("rstd_rd_mem",  128'(ev_addr.size()), 128'(1));
        chk("rstd_rd_is_rd", 128'(ev_wr[0]),   128'(0));
        chk("rstd_rd_addr", 128'(ev_addr[0]), 128'(16'h6660));
        chk("rstd_rd_data", rd, df);
        repeat (5) @(posedge clk);
        #1;
        chk("rstd_stay_empty", 128'(bus.buf_count), 128'(0));

        chk("never_rd_and_wr", 128'(both_seen), 128'(0));
        chk("count_le_depth",  128'(over_seen), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cache_writeback_buffer.md
Name: cache_writeback_buffer

Overview:
- Sits directly downstream of the L1 cache, between the cache's physical-memory port and physical memory.
- Absorbs 128-bit dirty-line evictions into a small FIFO and acknowledges them quickly. The cache's miss-refill read can then proceed without waiting for the writeback.
- Forwards buffered lines to refill reads that hit the buffer.
- Drains buffered lines to physical memory when the cache is quiet, or when the buffer is full.

Parameters:
DEPTH, 2, number of 128-bit line entries (legal 1..4)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
cache_address  in  16  line address from cache; bits [3:0] ignored
cache_read  in  1  line read request; held until cache_resp
cache_write  in  1  line write (eviction) request; held until cache_resp
cache_wdata  in  128  eviction line data
cache_resp  out  1  one-cycle completion pulse to cache
cache_rdata  out  128  read line data; valid when cache_resp is high after a read
pmem_address  out  16  memory line address; bits [3:0] always 0
pmem_read  out  1  memory read request; held until pmem_resp
pmem_write  out  1  memory write request; held until pmem_resp
pmem_wdata  out  128  memory write data
pmem_resp  in  1  memory completion
pmem_rdata  in  128  memory read data
buf_count  out  3  number of valid entries (0..DEPTH)

Behaviour:
- Line tag for all matches is address[15:4]. Each entry holds a valid bit, the tag and 128 bits of data. Entries are kept in FIFO order (head = oldest).
- Reset:
  - All entries are invalid; buf_count=0.
  - cache_resp, pmem_read and pmem_write are 0. cache_rdata, pmem_wdata and pmem_address are 0.
  - FSM goes to IDLE.
  - Reset mid-transaction abandons the transaction; pmem_read/pmem_write are low in the cycle after reset is sampled.
- FSM states: IDLE, RESP, MEM_RD, DRAIN.
- IDLE, checked in priority order each cycle:
  1. cache_write with tag match on a valid entry: overwrite that entry's data in place (coalesce); count unchanged; go to RESP.
  2. cache_write, no match, count<DEPTH: push at tail; count+1; go to RESP.
  3. cache_write, no match, count==DEPTH: go to DRAIN; the write stays pending and is retried in IDLE after the drain.
  4. cache_read with tag match: load cache_rdata from the matching entry; go to RESP; no memory access.
  5. cache_read, no match: drive pmem_address={tag,4'b0000} and pmem_read=1; go to MEM_RD.
     - The read bypasses the buffered writes; this is safe because no entry matches.
  6. No request and count>0: drive head entry onto pmem_address/pmem_wdata with pmem_write=1; go to DRAIN.
- If cache_read and cache_write are both high, the write is served first and the read stays pending.
- RESP: cache_resp=1 for exactly one cycle, then return to IDLE.
  - A request is never accepted in RESP, because the cache drops its request on cache_resp.
- MEM_RD: hold pmem_read and pmem_address stable. On pmem_resp, capture pmem_rdata into cache_rdata, drop pmem_read next cycle, and go to RESP.
- DRAIN: hold pmem_write, pmem_address and pmem_wdata stable. On pmem_resp, pop the head (count-1), drop pmem_write next cycle, and return to IDLE.
  - Upstream requests are not served during DRAIN, so the draining entry can never be coalesced into.
- Latency:
  - Buffered write, no stall: request sampled in cycle N → cache_resp in cycle N+2 (IDLE→RESP).
  - Read forward: same as a buffered write, cache_resp in N+2.
  - Read miss: cache_resp in the cycle after the cycle pmem_resp arrives + 1 (MEM_RD→RESP).
- pmem_read and pmem_write are never high together. pmem_resp outside MEM_RD/DRAIN is ignored.
- buf_count never exceeds DEPTH and never underflows.
- Coalescing keeps a single entry per tag, so any forward hit is unique.

Test Plan:
- Eviction accepted:
  - Stimulus: write 0x1230, data A, empty buffer.
  - Response: cache_resp 2 cycles later; buf_count=1; no pmem_write until the cache goes idle.
  - Then: pmem_write with address 0x1230, wdata A, held until pmem_resp; then buf_count=0.
- Forward hit:
  - Stimulus: write 0x4440 data B, then immediately read 0x444C.
  - Response: cache_rdata=B and cache_resp with no pmem_read asserted.
- Read miss bypass:
  - Stimulus: buffer holds 0x1000; read 0x2000.
  - Response: pmem_read at 0x2000 goes out before any drain; memory returns C after 5 cycles; cache_rdata=C; afterwards 0x1000 drains.
- Full stall (DEPTH=2):
  - Stimulus: buffer holds 0x0010 and 0x0020; write 0x0030.
  - Response: 0x0010 drains first; after its pmem_resp the write is accepted; buf_count=2 with entries 0x0020 and 0x0030.
- Coalesce:
  - Stimulus: write 0x5550 data D1, then write 0x5550 data D2.
  - Response: buf_count=1; the drain writes D2.
- Reset mid-drain:
  - Stimulus: assert reset while pmem_write=1.
  - Response: next cycle pmem_write=0, buf_count=0 and cache_resp=0; a subsequent read of the old address goes to memory.
